// File: rtl/keypad_entry_scanner_pkg.sv
// Shared constants, frame-result encodings and key map for the keypad entry scanner.
package keypad_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'd10;
    localparam logic [3:0] KEY_BKSP    = 4'hB;
    localparam logic [3:0] KEY_ENTER   = 4'hE;

    // Frame results: {1'b0, code} for a single key, otherwise one of these.
    localparam logic [4:0] FR_NOKEY   = 5'h10;
    localparam logic [4:0] FR_INVALID = 5'h11;

    localparam int ST_IDLE = 0;

    // Row r, column c at nibble (r*4+c).
    localparam logic [63:0] KEYMAP = 64'hFDCA_E369_B258_0147;

    function automatic int st_locked(input int channels);
        return channels + 1;
    endfunction

    function automatic logic [3:0] keymap(input int r, input int c);
        if (r < 4 && c < 4)
            return KEYMAP[(r * 4 + c) * 4 +: 4];
        return 4'(r * 4 + c);
    endfunction

endpackage

// File: rtl/keypad_entry_scanner_if.sv
// Keypad matrix lines: row strobes out of the scanner, column senses back in.
interface keypad_entry_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    logic [ROWS-1:0] keypadrow;
    logic [COLS-1:0] keypadcol;

    modport master (output keypadrow, input keypadcol);
    modport slave  (input keypadrow, output keypadcol);
endinterface

// File: rtl/keypad_entry_scanner_debounce.sv
// Turns per-frame scan results into single key-press events.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       frame_vld,
    input  logic [4:0] frame,
    output logic       accept,
    output logic [3:0] accept_code,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;

    assign accept_code = frame[3:0];
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;

    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        pressed_d  = pressed_q;
        key_code_d = key_code_q;
        accept     = 1'b0;
        if (clr) begin
            cand_d    = FR_NOKEY;
            cnt_d     = '0;
            pressed_d = 1'b0;
        end else if (frame_vld) begin
            if (frame == FR_INVALID) begin
                cand_d = FR_INVALID;
                cnt_d  = '0;
            end else begin
                if (frame != cand_q) begin
                    cand_d = frame;
                    cnt_d  = CW'(1);
                end else if (cnt_q != CW'(DEBOUNCE)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Stable long enough: a release re-arms, a press fires once.
                if (cnt_d == CW'(DEBOUNCE)) begin
                    if (frame == FR_NOKEY) begin
                        pressed_d = 1'b0;
                    end else if (!pressed_q) begin
                        pressed_d  = 1'b1;
                        accept     = 1'b1;
                        key_code_d = frame[3:0];
                    end
                end
            end
        end
        key_valid_d = accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q      <= FR_NOKEY;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= BLANK_DIGIT;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            pressed_q   <= pressed_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

endmodule

// File: rtl/keypad_entry_scanner.sv
// Keypad matrix scanner, per-player digit entry registers and game-phase FSM.
module keypad_entry_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 250000,
    parameter int DEBOUNCE = 3,
    parameter int CHANNELS = 2,
    parameter int DIGITS   = 2,
    localparam int SW      = $clog2(CHANNELS + 2),
    localparam int EW      = CHANNELS * DIGITS * 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  logic                   clear,
    keypad_entry_scanner_if.master kp,
    output logic [SW-1:0]          game_state,
    output logic                   key_valid,
    output logic [3:0]             key_code,
    output logic [EW-1:0]          entry
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [SW-1:0] ST_IDLE_V = SW'(ST_IDLE);
    localparam logic [SW-1:0] ST_LOCK_V = SW'(st_locked(CHANNELS));

    logic [SW-1:0] state_q, state_d;
    logic [EW-1:0] entry_q, entry_d;
    logic [DW-1:0] div_q, div_d;
    logic [RW-1:0] row_q, row_d;
    logic          acc_any_q, acc_any_d;
    logic          acc_multi_q, acc_multi_d;
    logic [3:0]    acc_code_q, acc_code_d;
    logic          frame_vld_q, frame_vld_d;
    logic [4:0]    frame_q, frame_d;

    logic          in_entry;
    logic          accept;
    logic [3:0]    accept_code;
    logic          key_acc;
    logic          go;
    logic [COLS-1:0] low;
    logic          row_any, row_multi;
    logic [3:0]    row_code;

    assign in_entry    = (state_q != ST_IDLE_V) && (state_q < ST_LOCK_V);
    assign kp.keypadrow = in_entry ? ~(ROWS'(1) << row_q) : '1;
    assign game_state  = state_q;
    assign entry       = entry_q;
    assign key_acc     = accept && in_entry;

    keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .clr        (!in_entry),
        .frame_vld  (frame_vld_q),
        .frame      (frame_q),
        .accept     (accept),
        .accept_code(accept_code),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    always_comb begin
        low       = ~kp.keypadcol;
        row_any   = 1'b0;
        row_multi = 1'b0;
        row_code  = 4'd0;
        for (int c = 0; c < COLS; c++) begin
            if (low[c]) begin
                if (row_any) row_multi = 1'b1;
                row_any  = 1'b1;
                row_code = keymap(int'(row_q), c);
            end
        end
    end

    always_comb begin
        div_d       = div_q;
        row_d       = row_q;
        acc_any_d   = acc_any_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        frame_vld_d = 1'b0;
        frame_d     = frame_q;
        if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (row_any) begin
                acc_multi_d = acc_multi_q | acc_any_q | row_multi;
                acc_any_d   = 1'b1;
                acc_code_d  = row_code;
            end
            if (row_q == RW'(ROWS - 1)) begin
                row_d       = '0;
                frame_vld_d = 1'b1;
                frame_d     = acc_multi_d ? FR_INVALID :
                              acc_any_d   ? {1'b0, acc_code_d} : FR_NOKEY;
                acc_any_d   = 1'b0;
                acc_multi_d = 1'b0;
            end else begin
                row_d = row_q + RW'(1);
            end
        end else begin
            div_d = div_q + DW'(1);
        end

        state_d = state_q;
        entry_d = entry_q;
        go      = advance || (key_acc && accept_code == KEY_ENTER);
        if (clear && state_q != ST_LOCK_V) begin
            state_d = ST_IDLE_V;
        end else if (go) begin
            if (state_q != ST_LOCK_V) state_d = state_q + SW'(1);
        end else if (key_acc) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (state_q == SW'(c + 1)) begin
                    if (accept_code <= 4'd9) begin
                        for (int d = DIGITS - 1; d > 0; d--)
                            entry_d[(c*DIGITS+d)*4 +: 4] = entry_q[(c*DIGITS+d-1)*4 +: 4];
                        entry_d[c*DIGITS*4 +: 4] = accept_code;
                    end else if (accept_code == KEY_BKSP) begin
                        for (int d = 0; d < DIGITS - 1; d++)
                            entry_d[(c*DIGITS+d)*4 +: 4] = entry_q[(c*DIGITS+d+1)*4 +: 4];
                        entry_d[(c*DIGITS+DIGITS-1)*4 +: 4] = BLANK_DIGIT;
                    end
                end
            end
        end
        if (state_d == ST_IDLE_V) entry_d = {(CHANNELS*DIGITS){BLANK_DIGIT}};

        // Every phase change restarts the scan at row 0 with an empty frame.
        if (!in_entry || state_d != state_q) begin
            div_d       = '0;
            row_d       = '0;
            acc_any_d   = 1'b0;
            acc_multi_d = 1'b0;
            frame_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE_V;
            entry_q     <= {(CHANNELS*DIGITS){BLANK_DIGIT}};
            div_q       <= '0;
            row_q       <= '0;
            acc_any_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
            frame_vld_q <= 1'b0;
            frame_q     <= FR_NOKEY;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            div_q       <= div_d;
            row_q       <= row_d;
            acc_any_q   <= acc_any_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            frame_vld_q <= frame_vld_d;
            frame_q     <= frame_d;
        end
    end

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed self-checking bench for keypad_entry_scanner with a small keypad matrix model.
module tb_keypad_entry_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        advance;
    logic        clear;
    logic [15:0] keys;
    logic [3:0]  cols;
    logic [1:0]  game_state;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry;
    int          checks = 0;
    int          failures = 0;
    int          kv_cnt = 0;
    int          kv_base;

    keypad_entry_scanner_if #(.ROWS(4), .COLS(4)) kp ();

    keypad_entry_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2),
        .CHANNELS(2), .DIGITS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .clear     (clear),
        .kp        (kp.master),
        .game_state(game_state),
        .key_valid (key_valid),
        .key_code  (key_code),
        .entry     (entry)
    );

    always #5 clk = ~clk;

    // Pressed key at (r,c) pulls column c low while row r is strobed low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.keypadrow[r]) cols[c] = 1'b0;
    end
    assign kp.keypadcol = cols;

    always @(posedge clk) if (key_valid) kv_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_adv();
        advance = 1'b1;
        step(1);
        advance = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0; clear = 1'b0; keys = '0;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_state", 32'(game_state), 32'd0);
        chk("rst_row", 32'(kp.keypadrow), 32'hF);
        chk("rst_entry", 32'(entry), 32'hAAAA);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'hA);

        pulse_adv();
        chk("scan_row0", 32'(kp.keypadrow), 32'hE);
        step(4);
        chk("scan_row1", 32'(kp.keypadrow), 32'hD);

        kv_base = kv_cnt;
        keys = 16'h0020;
        step(64);
        chk("one_event", 32'(kv_cnt - kv_base), 32'd1);
        chk("code_5", 32'(key_code), 32'h5);
        chk("entry_a5", 32'(entry[7:0]), 32'hA5);
        keys = '0; step(48);
        keys = 16'h0004; step(64);
        chk("entry_51", 32'(entry[7:0]), 32'h51);
        keys = '0; step(48);
        keys = 16'h0080; step(64);
        chk("bksp_a5", 32'(entry[7:0]), 32'hA5);
        keys = '0; step(48);
        keys = 16'h0800; step(64);
        chk("enter_st2", 32'(game_state), 32'd2);
        keys = '0; step(48);
        keys = 16'h0100; step(64);
        keys = '0; step(48);
        keys = 16'h0400; step(64);
        keys = '0; step(48);
        chk("entry_93a5", 32'(entry), 32'h93A5);
        chk("events_6", 32'(kv_cnt - kv_base), 32'd6);
        pulse_adv();
        chk("locked", 32'(game_state), 32'd3);
        chk("locked_row", 32'(kp.keypadrow), 32'hF);
        clear = 1'b1; step(1); clear = 1'b0;
        chk("clr_locked", 32'(game_state), 32'd3);
        chk("locked_entry", 32'(entry), 32'h93A5);

        do_reset();
        pulse_adv();
        kv_base = kv_cnt;
        keys = 16'h0003; step(80);
        keys = '0; step(48);
        keys = 16'h0001; step(10);
        keys = '0; step(48);
        chk("ghost_bounce", 32'(kv_cnt - kv_base), 32'd0);
        chk("ghost_entry", 32'(entry), 32'hAAAA);
        keys = 16'h0001; step(64);
        keys = '0; step(48);
        chk("after_ghost", 32'(entry), 32'hAAA7);

        do_reset();
        pulse_adv();
        keys = 16'h0100;
        step(32);
        advance = 1'b1; step(1); advance = 1'b0;
        chk("dig_adv_kv", 32'(key_valid), 32'd1);
        chk("dig_adv_st", 32'(game_state), 32'd2);
        chk("dig_adv_ent", 32'(entry), 32'hAAAA);
        keys = '0; step(48);
        keys = 16'h0001; step(64);
        keys = '0; step(48);
        chk("ch1_a7", 32'(entry), 32'hA7AA);
        advance = 1'b1; clear = 1'b1; step(1);
        advance = 1'b0; clear = 1'b0;
        chk("clr_adv_st", 32'(game_state), 32'd0);
        chk("clr_adv_ent", 32'(entry), 32'hAAAA);

        do_reset();
        pulse_adv();
        keys = 16'h0800;
        step(32);
        advance = 1'b1; step(1); advance = 1'b0;
        chk("ent_adv_kv", 32'(key_valid), 32'd1);
        chk("ent_adv_st", 32'(game_state), 32'd2);
        keys = '0; step(48);
        keys = 16'h0010; step(64);
        keys = '0; step(48);
        chk("ch1_a8", 32'(entry), 32'hA8AA);
        keys = 16'h0010; step(20);
        reset = 1'b1; step(1);
        chk("mid_rst_st", 32'(game_state), 32'd0);
        chk("mid_rst_row", 32'(kp.keypadrow), 32'hF);
        chk("mid_rst_kv", 32'(key_valid), 32'd0);
        chk("mid_rst_code", 32'(key_code), 32'hA);
        chk("mid_rst_ent", 32'(entry), 32'hAAAA);
        reset = 1'b0; keys = '0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
